// File: rtl/aes_mix_columns_seq_pkg.sv
// Shared AES helpers for the encrypt-side MixColumns datapath.
//   AES_POLY_LOW  : low byte of the AES field polynomial 0x11b
//   gf_xtime      : multiply a byte by {02} in GF(2^8)
//   gf_mul3       : multiply a byte by {03} in GF(2^8)
//   state_col     : extract column c (bits [127-32c -: 32]) of a 128-bit state
//   state_set_col : return a state with column c replaced
//   mc_state_t    : sequencer states IDLE / BUSY / DONE
package aes_mix_columns_seq_pkg;

   localparam logic [7:0] AES_POLY_LOW = 8'h1b;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mc_state_t;

   function automatic logic [7:0] gf_xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_LOW : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] x);
      return gf_xtime(x) ^ x;
   endfunction

   function automatic logic [31:0] state_col(input logic [127:0] s,
                                             input int unsigned  c);
      return s[127 - 32*c -: 32];
   endfunction

   function automatic logic [127:0] state_set_col(input logic [127:0] s,
                                                  input int unsigned  c,
                                                  input logic [31:0]  v);
      logic [127:0] r;
      r = s;
      r[127 - 32*c -: 32] = v;
      return r;
   endfunction

endpackage

// File: rtl/aes_mix_columns_seq_column.sv
// Combinational forward MixColumns for a single column.
//   col_in  : column bytes a0..a3, a0 in [31:24]
//   col_out : mixed column bytes b0..b3, b0 in [31:24]
module aes_mix_column
   import aes_mix_columns_seq_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      a0 = col_in[31:24];
      a1 = col_in[23:16];
      a2 = col_in[15:8];
      a3 = col_in[7:0];
      col_out[31:24] = gf_xtime(a0) ^ gf_mul3(a1)  ^ a2           ^ a3;
      col_out[23:16] = a0           ^ gf_xtime(a1) ^ gf_mul3(a2)  ^ a3;
      col_out[15:8]  = a0           ^ a1           ^ gf_xtime(a2) ^ gf_mul3(a3);
      col_out[7:0]   = gf_mul3(a0)  ^ a1           ^ a2           ^ gf_xtime(a3);
   end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Iterative forward MixColumns engine, COLS_PER_CYCLE columns per BUSY cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for in_state / in_bypass
//   in_state            : 128-bit state, s0 in [127:120], column 0 in [127:96]
//   in_bypass           : pass the state through unmixed (final round)
//   out_valid/out_ready : output handshake, out_state held until taken
//   out_state           : mixed (or bypassed) state, same byte order
module aes_mix_columns_seq
   import aes_mix_columns_seq_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_bypass,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   localparam int unsigned BUSY_CYCLES = 4 / COLS_PER_CYCLE;
   // With 4 columns per cycle the step wraps to 0; harmless since the
   // single BUSY cycle is also the last one.
   localparam logic [1:0]  COL_STEP    = 2'(COLS_PER_CYCLE % 4);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   mc_state_t    state;
   logic [1:0]   col;
   logic [127:0] work;
   logic         bypass;
   logic [127:0] next_work;
   logic         last;

   logic [31:0]  mix_in  [COLS_PER_CYCLE];
   logic [31:0]  mix_out [COLS_PER_CYCLE];

   // col is always a multiple of COLS_PER_CYCLE, so col+g never exceeds 3.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
      always_comb mix_in[g] = state_col(work, 32'(col) + g);

      aes_mix_column u_mix (
         .col_in  (mix_in[g]),
         .col_out (mix_out[g])
      );
   end

   always_comb begin
      next_work = work;
      if (!bypass) begin
         for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            next_work = state_set_col(next_work, 32'(col) + g, mix_out[g]);
         end
      end
      last = ((32'(col) / COLS_PER_CYCLE) == BUSY_CYCLES - 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col       <= '0;
         work      <= '0;
         bypass    <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_state <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_ready && in_valid) begin
                  work     <= in_state;
                  bypass   <= in_bypass;
                  col      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            BUSY: begin
               work <= next_work;
               col  <= col + COL_STEP;
               if (last) begin
                  out_valid <= 1'b1;
                  out_state <= next_work;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Self-checking bench for aes_mix_columns_seq: three instances with
// COLS_PER_CYCLE = 1, 2, 4, directed vectors plus randomized traffic
// compared against a matrix-multiply GF(2^8) reference model.
module tb_aes_mix_columns_seq;

   localparam logic [127:0] APPB_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] APPB_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] VEC_A_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] VEC_A_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] VEC_B_IN  = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
   localparam logic [127:0] VEC_B_OUT = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_state  [3];
   logic         in_bypass [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_state [3];

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_state  (in_state[g]),
         .in_bypass (in_bypass[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g])
      );
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Carry-less product followed by polynomial reduction modulo 0x11b.
   function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int k = 0; k < 8; k++)
         if (b[k]) p ^= 16'(a) << k;
      for (int k = 15; k >= 8; k--)
         if (p[k]) p ^= 16'h011b << (k - 8);
      return p[7:0];
   endfunction

   // Circulant matrix with first row {02,03,01,01}, applied per column.
   function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic byp);
      logic [7:0]   coef [4];
      logic [127:0] r;
      logic [7:0]   acc;
      if (byp) return s;
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc ^= gf_mul_ref(coef[(j - row + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
            r[127 - 8*(4*c + row) -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic int lat_of(input int i);
      return 4 >> i;
   endfunction

   function automatic logic [127:0] rand_state();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Present one block and return just after the accepting edge.
   task automatic send(input int i, input logic [127:0] st, input logic byp);
      in_state[i]  = st;
      in_bypass[i] = byp;
      in_valid[i]  = 1'b1;
      for (int n = 0; n < 64 && !in_ready[i]; n++) begin
         @(posedge clk); #1;
      end
      if (!in_ready[i]) check($sformatf("c%0d_send_timeout", i), 128'(in_ready[i]), 128'(1));
      else begin
         @(posedge clk); #1;
      end
      in_valid[i] = 1'b0;
   endtask

   // Wait for out_valid, checking latency and in_ready; scrambles in_state
   // meanwhile. Leaves the DUT in DONE without consuming.
   task automatic wait_done(input int i, input string tag, output logic [127:0] seen);
      int k;
      k = 0;
      while (!out_valid[i] && k < 64) begin
         check($sformatf("c%0d_%s_busy_rdy", i, tag), 128'(in_ready[i]), 128'(0));
         in_state[i] = rand_state();
         @(posedge clk); #1;
         k++;
      end
      check($sformatf("c%0d_%s_lat", i, tag), 128'(k), 128'(lat_of(i)));
      check($sformatf("c%0d_%s_done_rdy", i, tag), 128'(in_ready[i]), 128'(0));
      seen = out_state[i];
   endtask

   task automatic recv(input int i, input string tag, input logic [127:0] exp);
      logic [127:0] seen;
      out_ready[i] = 1'b1;
      wait_done(i, tag, seen);
      check($sformatf("c%0d_%s_data", i, tag), seen, exp);
      @(posedge clk); #1;
      check($sformatf("c%0d_%s_drop_vld", i, tag), 128'(out_valid[i]), 128'(0));
      check($sformatf("c%0d_%s_idle_rdy", i, tag), 128'(in_ready[i]), 128'(1));
   endtask

   task automatic directed(input int i);
      logic [127:0] seen, v, e, nxt;
      // FIPS-197 App. B round 1
      send(i, APPB_IN, 1'b0);
      recv(i, "appb", APPB_OUT);
      // packed single-column vectors, checked column by column
      for (int p = 0; p < 2; p++) begin
         v = (p == 0) ? VEC_A_IN : VEC_B_IN;
         e = (p == 0) ? VEC_A_OUT : VEC_B_OUT;
         send(i, v, 1'b0);
         out_ready[i] = 1'b1;
         wait_done(i, $sformatf("vec%0d", p), seen);
         for (int c = 0; c < 4; c++)
            check($sformatf("c%0d_vec%0d_col%0d", i, p, c),
                  128'(seen[127 - 32*c -: 32]), 128'(e[127 - 32*c -: 32]));
         @(posedge clk); #1;
      end
      // bypass
      send(i, APPB_IN, 1'b1);
      recv(i, "bypass", APPB_IN);
      // backpressure with a competing input held valid
      out_ready[i] = 1'b0;
      send(i, APPB_IN, 1'b0);
      wait_done(i, "bp", seen);
      nxt = rand_state();
      in_state[i]  = nxt;
      in_bypass[i] = 1'b0;
      in_valid[i]  = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         check($sformatf("c%0d_bp_vld", i), 128'(out_valid[i]), 128'(1));
         check($sformatf("c%0d_bp_data", i), out_state[i], APPB_OUT);
         check($sformatf("c%0d_bp_rdy", i), 128'(in_ready[i]), 128'(0));
      end
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("c%0d_bp_release_vld", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("c%0d_bp_release_rdy", i), 128'(in_ready[i]), 128'(1));
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      recv(i, "bp_next", mix_ref(nxt, 1'b0));
      // reset during the second BUSY cycle (DONE when one cycle suffices)
      send(i, rand_state(), 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check($sformatf("c%0d_rst_vld", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("c%0d_rst_data", i), out_state[i], 128'(0));
      @(posedge clk); #1;
      check($sformatf("c%0d_rst_rdy", i), 128'(in_ready[i]), 128'(1));
      check($sformatf("c%0d_rst_vld2", i), 128'(out_valid[i]), 128'(0));
      send(i, VEC_B_IN, 1'b0);
      recv(i, "after_rst", VEC_B_OUT);
   endtask

   task automatic random_traffic(input int i, input int n);
      logic [127:0] q [$];
      int got_n;
      got_n = 0;
      fork
         begin
            logic [127:0] st;
            logic         byp;
            for (int b = 0; b < n; b++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk); #1;
               end
               st  = rand_state();
               byp = ($urandom_range(0, 7) == 0);
               q.push_back(mix_ref(st, byp));
               send(i, st, byp);
            end
         end
         begin
            int budget;
            budget = n * 40;
            while (got_n < n && budget > 0) begin
               out_ready[i] = ($urandom_range(0, 3) != 0);
               if (out_valid[i] && out_ready[i]) begin
                  if (q.size() == 0)
                     check($sformatf("c%0d_rand_unexpected", i), 128'(q.size()), 128'(1));
                  else
                     check($sformatf("c%0d_rand_data", i), out_state[i], q.pop_front());
                  got_n++;
               end
               @(posedge clk); #1;
               budget--;
            end
            out_ready[i] = 1'b1;
         end
      join
      check($sformatf("c%0d_rand_count", i), 128'(got_n), 128'(n));
      check($sformatf("c%0d_rand_leftover", i), 128'(q.size()), 128'(0));
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("c%0d_rand_no_dup", i), 128'(out_valid[i]), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         in_state[i]  = '0;
         in_bypass[i] = 1'b0;
         out_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("c%0d_reset_rdy", i), 128'(in_ready[i]), 128'(0));
         check($sformatf("c%0d_reset_vld", i), 128'(out_valid[i]), 128'(0));
         check($sformatf("c%0d_reset_data", i), out_state[i], 128'(0));
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("c%0d_idle_rdy", i), 128'(in_ready[i]), 128'(1));

      for (int i = 0; i < 3; i++) directed(i);
      random_traffic(0, 1000);
      random_traffic(1, 200);
      random_traffic(2, 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
